// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: debounce FSM states,
// key code map and column strobe helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HELD,
        ST_RELEASE
    } kp_state_t;

    // First column strobed after reset (column 0 driven low).
    localparam logic [3:0] COL_INIT = 4'he;

    // Key codes indexed by {row, col}.
    localparam logic [3:0] KEYMAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Rotate the active-low strobe: e -> d -> b -> 7 -> e.
    function automatic logic [3:0] col_next(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan-rate enable generator: one-clock tick every CLK_HZ/SCAN_HZ clocks.
module keypad_scan_tick #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ = 1_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST   = CW'(SCAN_DIV - 1);

    logic [CW-1:0] tick_cnt;

    // Free-running divider, wraps at SCAN_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: column strobing, ROW synchroniser, frame
// decode and debounce FSM producing hexValue/nokey and a key_valid strobe.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned SCAN_HZ         = 1_000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_FRAMES   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] hexValue,
    output logic       nokey,
    output logic       key_valid
);
    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_FRAMES);

    logic       tick;
    logic [3:0] row_meta, row_s;
    logic [1:0] col_idx;
    logic       acc_hit;
    logic [3:0] acc_key;
    logic       cur_hit;
    logic [1:0] cur_row;
    logic [3:0] cur_key;
    logic       frame_end, fr_hit, same_key;
    logic [3:0] fr_key;
    kp_state_t  state, state_n;
    logic [3:0] cnt, cnt_n, cnt_inc, cand, cand_n, hex_n;
    logic       nokey_n, kv_n;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RW       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
    logic [RW-1:0] rep_cnt, rep_n;
`endif

    keypad_scan_tick #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchroniser for the asynchronous, pulled-up rows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hf;
            row_s    <= 4'hf;
        end else begin
            row_meta <= ROW;
            row_s    <= row_meta;
        end
    end

    // Column strobe advances after the current column has been sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            COL     <= COL_INIT;
            col_idx <= '0;
        end else if (tick) begin
            COL     <= col_next(COL);
            col_idx <= col_idx + 2'd1;
        end
    end

    // Lowest-numbered low row in the column being sampled
    always_comb begin
        cur_hit = 1'b0;
        cur_row = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!cur_hit && !row_s[r]) begin
                cur_hit = 1'b1;
                cur_row = 2'(r);
            end
        end
        cur_key = KEYMAP[{cur_row, col_idx}];
    end

    // Frame result merges the latched first hit with the final column's sample
    assign frame_end = tick && (col_idx == 2'd3);
    assign fr_hit    = acc_hit | cur_hit;
    assign fr_key    = acc_hit ? acc_key : cur_key;
    assign same_key  = fr_hit && (fr_key == cand);
    assign cnt_inc   = (cnt == 4'hf) ? cnt : cnt + 4'd1;

    // First hit of the frame wins; cleared at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit <= 1'b0;
            acc_key <= '0;
        end else if (tick) begin
            if (col_idx == 2'd3) begin
                acc_hit <= 1'b0;
                acc_key <= '0;
            end else if (!acc_hit && cur_hit) begin
                acc_hit <= 1'b1;
                acc_key <= cur_key;
            end
        end
    end

    // Debounce state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= '0;
            hexValue  <= '0;
            nokey     <= 1'b1;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            hexValue  <= hex_n;
            nokey     <= nokey_n;
            key_valid <= kv_n;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_n;
`endif
        end
    end

    // Debounce next-state, evaluated once per frame end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        hex_n   = hexValue;
        nokey_n = nokey;
        kv_n    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = rep_cnt;
`endif
        if (frame_end) begin
`ifdef KEYPAD_REPEAT_EN
            rep_n = '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (fr_hit) begin
                        cand_n = fr_key;
                        if (DB_LIMIT <= 4'd1) begin
                            state_n = ST_HELD;
                            cnt_n   = '0;
                            hex_n   = fr_key;
                            nokey_n = 1'b0;
                            kv_n    = 1'b1;
                        end else begin
                            state_n = ST_PRESS;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                ST_PRESS: begin
                    if (same_key) begin
                        if (cnt_inc >= DB_LIMIT) begin
                            state_n = ST_HELD;
                            cnt_n   = '0;
                            hex_n   = cand;
                            nokey_n = 1'b0;
                            kv_n    = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
                ST_HELD: begin
                    if (same_key) begin
                        cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt >= REP_LAST) begin
                            kv_n = 1'b1;
                        end else begin
                            rep_n = rep_cnt + 1'b1;
                        end
`endif
                    end else if (DB_LIMIT <= 4'd1) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        nokey_n = 1'b1;
                    end else begin
                        state_n = ST_RELEASE;
                        cnt_n   = 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (same_key) begin
                        state_n = ST_HELD;
                        cnt_n   = '0;
                    end else if (cnt_inc >= DB_LIMIT) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        nokey_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4 with a behavioural keypad matrix.
module tb_keypad_scan_4x4;

    localparam int unsigned DB  = 3;
    localparam int unsigned REP = 5;

    localparam logic [15:0] K0 = 16'h0000;
    localparam logic [15:0] K1 = 16'h0001;  // r0 c0
    localparam logic [15:0] KA = 16'h0008;  // r0 c3
    localparam logic [15:0] K5 = 16'h0020;  // r1 c1
    localparam logic [15:0] K9 = 16'h0400;  // r2 c2
    localparam logic [15:0] KD = 16'h8000;  // r3 c3

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] hexValue;
    logic       nokey;
    logic       key_valid;
    logic [15:0] keys = '0;   // bit row*4+col = key pressed

    int n_checks = 0;
    int n_errors = 0;
    int kv_seen = 0;
    int kv_expected = 0;

    keypad_scan_4x4 #(
        .CLK_HZ          (1000),
        .SCAN_HZ         (250),
        .DEBOUNCE_FRAMES (DB),
        .REPEAT_FRAMES   (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ROW       (ROW),
        .COL       (COL),
        .hexValue  (hexValue),
        .nokey     (nokey),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        ROW = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
    end

    always @(negedge clk) if (rst_n && key_valid) kv_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [3:0] kmap [0:3][0:3];
    bit         m_held;
    logic [3:0] m_cand, m_hex;
    int         m_run, m_miss, m_rep;
    bit         m_kv;

    task automatic model_reset();
        m_held = 0; m_cand = '0; m_hex = '0;
        m_run = 0; m_miss = 0; m_rep = 0; m_kv = 0;
    endtask

    // Key seen by a frame: scan order is column-major, lowest row first
    task automatic frame_decode(input logic [15:0] k, output bit hit, output logic [3:0] key);
        hit = 0; key = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!hit && k[r*4+c]) begin
                    hit = 1; key = kmap[r][c];
                end
    endtask

    task automatic model_frame(input logic [15:0] k);
        bit hit;
        logic [3:0] key;
        frame_decode(k, hit, key);
        m_kv = 0;
        if (!m_held) begin
            if (hit && m_run > 0 && key == m_cand) m_run++;
            else if (hit && m_run == 0) begin m_cand = key; m_run = 1; end
            else m_run = 0;
            if (m_run >= DB) begin
                m_held = 1; m_hex = m_cand; m_kv = 1; m_run = 0; m_rep = 0; m_miss = 0;
            end
        end else if (hit && key == m_cand) begin
            if (m_miss > 0) begin
                m_miss = 0; m_rep = 0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
                m_rep++;
                if (m_rep == REP) begin m_kv = 1; m_rep = 0; end
`endif
            end
        end else begin
            m_rep = 0;
            m_miss++;
            if (m_miss >= DB) begin m_held = 0; m_miss = 0; end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic run_frame(input logic [15:0] k);
        keys = k;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic frame_expect(input string name, input logic [15:0] k,
                                input logic nk, input logic [3:0] hx, input logic kv);
        run_frame(k);
        check1({name, "_nokey"}, nokey, nk);
        check4({name, "_hex"}, hexValue, hx);
        check1({name, "_kv"}, key_valid, kv);
        if (kv) kv_expected++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] k;
        logic        nk;
        logic [3:0]  hx;
        logic        kv;
    } vec_t;

    vec_t vtab[$];
    logic [3:0] col_seq [0:3];

    initial begin
        logic [15:0] prev, nk;
        int sel;

        kmap[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
        kmap[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
        kmap[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
        kmap[3] = '{4'hE, 4'h0, 4'hF, 4'hD};
        col_seq = '{4'he, 4'hd, 4'hb, 4'h7};

        // hold '5', release with a one-frame glitch, bounce on '9',
        // key change while held, two keys at once, different key during debounce
        vtab.push_back('{K5, 1'b1, 4'h0, 1'b0});
        vtab.push_back('{K5, 1'b1, 4'h0, 1'b0});
        vtab.push_back('{K5, 1'b0, 4'h5, 1'b1});
        vtab.push_back('{K5, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K5, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K0, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K0, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b0, 4'h9, 1'b1});
        vtab.push_back('{K0, 1'b0, 4'h9, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h9, 1'b0});
        vtab.push_back('{K0, 1'b1, 4'h9, 1'b0});
        vtab.push_back('{K5, 1'b1, 4'h9, 1'b0});
        vtab.push_back('{K5, 1'b1, 4'h9, 1'b0});
        vtab.push_back('{K5, 1'b0, 4'h5, 1'b1});
        vtab.push_back('{K9, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b0, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h5, 1'b0});
        vtab.push_back('{K9, 1'b0, 4'h9, 1'b1});
        vtab.push_back('{K0, 1'b0, 4'h9, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h9, 1'b0});
        vtab.push_back('{K0, 1'b1, 4'h9, 1'b0});
        vtab.push_back('{K1 | KD, 1'b1, 4'h9, 1'b0});
        vtab.push_back('{K1 | KD, 1'b1, 4'h9, 1'b0});
        vtab.push_back('{K1 | KD, 1'b0, 4'h1, 1'b1});
        vtab.push_back('{K0, 1'b0, 4'h1, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h1, 1'b0});
        vtab.push_back('{K0, 1'b1, 4'h1, 1'b0});
        vtab.push_back('{K5, 1'b1, 4'h1, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h1, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h1, 1'b0});
        vtab.push_back('{K9, 1'b1, 4'h1, 1'b0});
        vtab.push_back('{K9, 1'b0, 4'h9, 1'b1});
        vtab.push_back('{K0, 1'b0, 4'h9, 1'b0});
        vtab.push_back('{K0, 1'b0, 4'h9, 1'b0});
        vtab.push_back('{K0, 1'b1, 4'h9, 1'b0});

        // reset state while rst_n is held low
        #12;
        check4("rst_col", COL, 4'he);
        check4("rst_hex", hexValue, 4'h0);
        check1("rst_nokey", nokey, 1'b1);
        check1("rst_kv", key_valid, 1'b0);

        // column rotation with no key, two full frames
        do_reset();
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            #1;
            check4("col_rot", COL, col_seq[(n / 4) % 4]);
            if (n % 16 == 0) begin
                check1("idle_nokey", nokey, 1'b1);
                check1("idle_kv", key_valid, 1'b0);
            end
        end

        // directed frame table
        foreach (vtab[i]) begin
            run_frame(vtab[i].k);
            check1("tab_nokey", nokey, vtab[i].nk);
            check4("tab_hex", hexValue, vtab[i].hx);
            check1("tab_kv", key_valid, vtab[i].kv);
            if (vtab[i].kv) kv_expected++;
        end

        // asynchronous reset in the middle of a debounce
        frame_expect("pre_rst", K1 | KD, 1'b1, 4'h9, 1'b0);
        frame_expect("pre_rst", K1 | KD, 1'b1, 4'h9, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check4("mid_rst_col", COL, 4'he);
        check4("mid_rst_hex", hexValue, 4'h0);
        check1("mid_rst_nokey", nokey, 1'b1);
        check1("mid_rst_kv", key_valid, 1'b0);
        check_int("mid_rst_kv_count", kv_seen, kv_expected);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        frame_expect("post_rst", K1 | KD, 1'b1, 4'h0, 1'b0);
        frame_expect("post_rst", K1 | KD, 1'b1, 4'h0, 1'b0);
        frame_expect("post_rst", K1 | KD, 1'b0, 4'h1, 1'b1);
        frame_expect("post_rel", K0, 1'b0, 4'h1, 1'b0);
        frame_expect("post_rel", K0, 1'b0, 4'h1, 1'b0);
        frame_expect("post_rel", K0, 1'b1, 4'h1, 1'b0);

`ifdef KEYPAD_REPEAT_EN
        // auto-repeat on a held 'A'
        frame_expect("rep_acc", KA, 1'b1, 4'h1, 1'b0);
        frame_expect("rep_acc", KA, 1'b1, 4'h1, 1'b0);
        frame_expect("rep_acc", KA, 1'b0, 4'hA, 1'b1);
        for (int i = 1; i <= 13; i++)
            frame_expect("rep_hold", KA, 1'b0, 4'hA, (i == 5) || (i == 10));
        frame_expect("rep_rel", K0, 1'b0, 4'hA, 1'b0);
        frame_expect("rep_rel", K0, 1'b0, 4'hA, 1'b0);
        frame_expect("rep_rel", K0, 1'b1, 4'hA, 1'b0);
`endif

        // randomised frames against the reference model
        do_reset();
        prev = '0;
        for (int f = 0; f < 160; f++) begin
            sel = $urandom_range(0, 99);
            if (sel < 45)      nk = prev;
            else if (sel < 65) nk = '0;
            else if (sel < 88) nk = 16'(1) << $urandom_range(0, 15);
            else               nk = 16'($urandom);
            prev = nk;
            run_frame(nk);
            model_frame(nk);
            check1("rand_nokey", nokey, !m_held);
            check4("rand_hex", hexValue, m_hex);
            check1("rand_kv", key_valid, m_kv);
            if (m_kv) kv_expected++;
        end

        repeat (2) @(posedge clk);
        check_int("kv_pulse_total", kv_seen, kv_expected);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
